// File: rtl/fetch_queue.sv
// Two-wide fetch buffer feeding the dual decoders; slot0 is always the oldest word and slot1 the next oldest.
// Latency is 1 cycle from push to slot. Define FETCH_QUEUE_BYPASS_EN to show the fetch lanes on the slots in the same cycle while the queue is empty.
// Backpressure: fetch_ready_o drops when fewer than 2 slots are free, and a push while it is low is dropped.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [1:0]  fetch_valid_i,
  input  logic [63:0] fetch_inst_i,
  input  logic [31:0] fetch_pc_i,
  output logic        fetch_ready_o,
  input  logic [1:0]  pop_i,
  output logic [63:0] instruction_o,
  output logic [63:0] pc_o,
  output logic [1:0]  was_fetched_o
);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [PTR_W:0]   count;
  logic [1:0]       n_push, n_req, n_pop, n_wr, n_adv;
  logic             bypass, wr_skip;
  logic [31:0]      pc1, wr0_inst, wr0_pc;

  assign fetch_ready_o = (count <= (PTR_W+1)'(DEPTH - 2));
  assign pc1           = fetch_pc_i + 32'd4;
  assign head_p1       = head + PTR_W'(1);
  assign tail_p1       = tail + PTR_W'(1);

  always_comb begin
    n_push = 2'd0;
    if (fetch_ready_o && !flush_i) begin
      case (fetch_valid_i)
        2'b01:   n_push = 2'd1;
        2'b11:   n_push = 2'd2;
        default: n_push = 2'd0;
      endcase
    end
    case (pop_i)
      2'b01:   n_req = 2'd1;
      2'b11:   n_req = 2'd2;
      default: n_req = 2'd0;
    endcase
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = (count == '0) && (n_push != 2'd0) && !rst_i;
`else
    bypass = 1'b0;
`endif
    // While bypassing, decode pops straight off the fetch lanes instead of storage.
    if (bypass) begin
      n_pop = (n_req > n_push) ? n_push : n_req;
      n_wr  = n_push - n_pop;
      n_adv = 2'd0;
    end else begin
      n_pop = (count >= (PTR_W+1)'(n_req)) ? n_req : count[1:0];
      n_wr  = n_push;
      n_adv = n_pop;
    end
    wr_skip  = bypass && (n_pop != 2'd0);
    wr0_inst = wr_skip ? fetch_inst_i[63:32] : fetch_inst_i[31:0];
    wr0_pc   = wr_skip ? pc1 : fetch_pc_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(n_wr);
      head  <= head + PTR_W'(n_adv);
      count <= count + (PTR_W+1)'(n_wr) - (PTR_W+1)'(n_adv);
    end
  end

  always_ff @(posedge clk_i) begin
    if (n_wr != 2'd0) begin
      inst_mem[tail] <= wr0_inst;
      pc_mem[tail]   <= wr0_pc;
    end
    if (n_wr == 2'd2) begin
      inst_mem[tail_p1] <= fetch_inst_i[63:32];
      pc_mem[tail_p1]   <= pc1;
    end
  end

  // Empty slots read as zero so the decoder emits an all-zero control word.
  always_comb begin
    was_fetched_o = 2'b00;
    instruction_o = 64'd0;
    pc_o          = 64'd0;
    if (bypass) begin
      was_fetched_o = fetch_valid_i;
      instruction_o[31:0] = fetch_inst_i[31:0];
      pc_o[31:0]          = fetch_pc_i;
      if (fetch_valid_i[1]) begin
        instruction_o[63:32] = fetch_inst_i[63:32];
        pc_o[63:32]          = pc1;
      end
    end else begin
      if (count > (PTR_W+1)'(0)) begin
        was_fetched_o[0]    = 1'b1;
        instruction_o[31:0] = inst_mem[head];
        pc_o[31:0]          = pc_mem[head];
      end
      if (count > (PTR_W+1)'(1)) begin
        was_fetched_o[1]     = 1'b1;
        instruction_o[63:32] = inst_mem[head_p1];
        pc_o[63:32]          = pc_mem[head_p1];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [1:0]  fetch_valid_i = 2'b00;
  logic [63:0] fetch_inst_i = 64'd0;
  logic [31:0] fetch_pc_i = 32'd0;
  logic        fetch_ready_o;
  logic [1:0]  pop_i = 2'b00;
  logic [63:0] instruction_o;
  logic [63:0] pc_o;
  logic [1:0]  was_fetched_o;

  int   n_chk = 0;
  int   n_fail = 0;
  ent_t q[$];

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_inst_i(fetch_inst_i), .fetch_pc_i(fetch_pc_i),
    .fetch_ready_o(fetch_ready_o), .pop_i(pop_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .was_fetched_o(was_fetched_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lanes_of(input logic [1:0] fv);
    return (fv == 2'b01) ? 1 : (fv == 2'b11) ? 2 : 0;
  endfunction

  function automatic logic model_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (q.size() == 0) && !flush_i && (lanes_of(fetch_valid_i) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Compare what the slots should show right now, given queue contents and current inputs.
  task automatic check_view(input string tag);
    logic [1:0]  wf;
    logic [63:0] ins, pcs;
    wf = 2'b00; ins = 64'd0; pcs = 64'd0;
    if (model_bypass()) begin
      wf = fetch_valid_i;
      ins[31:0] = fetch_inst_i[31:0];
      pcs[31:0] = fetch_pc_i;
      if (fetch_valid_i[1]) begin
        ins[63:32] = fetch_inst_i[63:32];
        pcs[63:32] = fetch_pc_i + 32'd4;
      end
    end else begin
      if (q.size() > 0) begin wf[0] = 1'b1; ins[31:0] = q[0].inst; pcs[31:0] = q[0].pc; end
      if (q.size() > 1) begin wf[1] = 1'b1; ins[63:32] = q[1].inst; pcs[63:32] = q[1].pc; end
    end
    chk({tag, ".ready"}, 64'(fetch_ready_o), 64'(DEPTH - q.size() >= 2));
    chk({tag, ".was_fetched"}, 64'(was_fetched_o), 64'(wf));
    chk({tag, ".instruction"}, instruction_o, ins);
    chk({tag, ".pc"}, pc_o, pcs);
  endtask

  task automatic model_update();
    ent_t lanes[$];
    int   npop;
    logic byp;
    byp = model_bypass();
    if (flush_i) begin
      q.delete();
      return;
    end
    if (DEPTH - q.size() >= 2) begin
      if (lanes_of(fetch_valid_i) >= 1) lanes.push_back({fetch_inst_i[31:0], fetch_pc_i});
      if (lanes_of(fetch_valid_i) == 2) lanes.push_back({fetch_inst_i[63:32], fetch_pc_i + 32'd4});
    end
    npop = lanes_of(pop_i);
    if (byp) begin
      for (int i = 0; i < npop && lanes.size() > 0; i++) void'(lanes.pop_front());
    end else begin
      for (int i = 0; i < npop && q.size() > 0; i++) void'(q.pop_front());
    end
    foreach (lanes[i]) q.push_back(lanes[i]);
  endtask

  task automatic step(input string tag, input logic fl, input logic [1:0] fv, input logic [1:0] pp,
                      input logic [63:0] ins, input logic [31:0] pc);
    flush_i = fl; fetch_valid_i = fv; pop_i = pp; fetch_inst_i = ins; fetch_pc_i = pc;
    #1;
    check_view(tag);
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    chk({tag, ".count"}, 64'(dut.count), 64'(q.size()));
  endtask

  task automatic push2(input string tag, input logic [31:0] pc);
    step(tag, 1'b0, 2'b11, 2'b00, {$urandom, $urandom}, pc);
  endtask

  task automatic pulse_reset(input string tag);
    rst_i = 1'b1;
    #1;
    q.delete();
    chk({tag, ".was_fetched"}, 64'(was_fetched_o), 64'd0);
    chk({tag, ".ready"}, 64'(fetch_ready_o), 64'd1);
    chk({tag, ".instruction"}, instruction_o, 64'd0);
    chk({tag, ".pc"}, pc_o, 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    logic [1:0] fv, pp;
    #2;
    chk("reset.was_fetched", 64'(was_fetched_o), 64'd0);
    chk("reset.ready", 64'(fetch_ready_o), 64'd1);
    chk("reset.instruction", instruction_o, 64'd0);
    chk("reset.pc", pc_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    step("t2.push", 1'b0, 2'b11, 2'b00, {32'h00A00113, 32'h00500093}, 32'h100);
    step("t2.view", 1'b0, 2'b00, 2'b00, 64'd0, 32'd0);
    chk("t2.pc_pair", pc_o, {32'h104, 32'h100});

    push2("t1.fill_a", 32'h200);
    step("t1.fill_b", 1'b0, 2'b01, 2'b00, {$urandom, $urandom}, 32'h300);
    chk("t1.count5", 64'(dut.count), 64'd5);
    pulse_reset("t1.reset");
    step("t1.after_push", 1'b0, 2'b01, 2'b00, {32'h0, 32'h11111111}, 32'h400);
    step("t1.slot0", 1'b0, 2'b00, 2'b00, 64'd0, 32'd0);

    pulse_reset("t3.reset");
    for (int i = 0; i < 4; i++) push2("t3.fill", 32'h1000 + 32'(i * 8));
    chk("t3.count8", 64'(dut.count), 64'd8);
    push2("t3.dropped", 32'h2000);
    chk("t3.still8", 64'(dut.count), 64'd8);

    step("t4.pop_a", 1'b0, 2'b00, 2'b11, 64'd0, 32'd0);
    step("t4.pop_b", 1'b0, 2'b00, 2'b11, 64'd0, 32'd0);
    step("t4.pop_c", 1'b0, 2'b00, 2'b01, 64'd0, 32'd0);
    step("t4.wrap", 1'b0, 2'b11, 2'b11, {$urandom, $urandom}, 32'h3000);
    chk("t4.count3", 64'(dut.count), 64'd3);
    for (int i = 0; i < 3; i++) step("t4.drain", 1'b0, 2'b00, 2'b01, 64'd0, 32'd0);

    for (int i = 0; i < 2; i++) push2("t5.fill", 32'h4000 + 32'(i * 8));
    step("t5.flush", 1'b1, 2'b11, 2'b01, {$urandom, $urandom}, 32'h5000);
    chk("t5.empty", 64'(was_fetched_o), 64'd0);

    step("t6.bypass", 1'b0, 2'b11, 2'b01, {32'hCAFE0001, 32'hBEEF0000}, 32'h6000);
    step("t6.next", 1'b0, 2'b00, 2'b00, 64'd0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    fv = 2'b00;
        2, 3:    fv = 2'b01;
        7:       fv = 2'b10;
        default: fv = 2'b11;
      endcase
      case ($urandom_range(0, 5))
        0, 1:    pp = 2'b00;
        2:       pp = 2'b10;
        3:       pp = 2'b01;
        default: pp = 2'b11;
      endcase
      step("rand", ($urandom_range(0, 29) == 0), fv, pp, {$urandom, $urandom}, $urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
